regbank32_write: RTL
====================

# regbank32_write

Write side of the 32 x 32-bit MIPS general-purpose register bank. Decodes a 5-bit write address into 32 one-hot enables and updates the selected register on the rising clock edge. All 32 register values are exposed in parallel, ready for the `mux32to1` read-port multiplexers. Register `$0` is hardwired to zero.

## Interface
Parameters:
- `WIDTH`, default 32: data width of each register.
- `NREGS`, fixed at 32: register count, tied to the 5-bit address.

Ports:
- `Clk`  in  1  system clock; all state updates on its rising edge.
- `Reset`  in  1  reset; synchronous, active-high.
- `WrEn`  in  1  write request for this cycle.
- `WrAddr`  in  5  destination register index, 0..31.
- `WrData`  in  WIDTH  value to write.
- `Q0` … `Q31`  out  WIDTH each  current register contents; connect to the `D0`..`D31` inputs of `mux32to1`.
- `WrDone`  out  1  one-cycle strobe: the previous cycle's write modified a register.
- `WrIdx`  out  5  index of the last committed write; valid while `WrDone`=1.

## Operation
- Decoder: `WrAddr` → one-hot `En[31:0]`. `En[i] = WrEn & (WrAddr == i)`. At most one bit is set.
- Register `i` for i=1..31:
  - if `Reset`, load 0;
  - else if `En[i]`, load `WrData`;
  - else hold.
- Register 0: `Q0` is constant 0. Writes to address 0 are accepted and discarded. `WrDone` stays 0 for them.
- `WrDone`/`WrIdx` are registered:
  - On an edge with `Reset`=0, `WrEn`=1 and `WrAddr`≠0: `WrDone`←1, `WrIdx`←`WrAddr`.
  - Otherwise `WrDone`←0 and `WrIdx` holds.
- Reset values: all `Q*` = 0, `WrDone` = 0, `WrIdx` = 0.
- `Reset` has priority over a simultaneous write. The write is lost and produces no `WrDone`.
- Reset asserted mid-stream clears every register on that edge. Writes resume on the first edge where `Reset`=0.
- No handshake back-pressure: a write is accepted every cycle `WrEn`=1.
- Back-to-back writes to the same register: the last edge wins.
- `WrData` is stored verbatim: no sign extension, no truncation when `WIDTH`=32.

## Timing
- Write latency 1 cycle: `Q[WrAddr]` shows `WrData` immediately after the capturing rising edge.
- No write-through bypass. A read through `mux32to1` in the same cycle as a write returns the old value. Pipeline forwarding handles this hazard outside this block.
- `WrDone` is asserted for exactly the cycle after the capturing edge. With consecutive writes it stays high continuously, and `WrIdx` updates every cycle.
- `WrEn`, `WrAddr` and `WrData` must be stable around the `Clk` rising edge. The decoder is combinational, with no internal pipeline.
- `X` on `WrAddr` while `WrEn`=0 has no effect.

## Structure
- Shared package `mips_pkg`:
  - `REG_W` = 32
  - `REG_ADDR_W` = 5
  - `NUM_REGS` = 32
  - `REG_ZERO` = 5'd0
  - MIPS register index constants: `REG_SP` = 29, `REG_RA` = 31
- Sub-module `decoder5to32`: inputs `En`, `Sel[4:0]`; output `Y[31:0]` one-hot. It is combinational and is the inverse of `mux32to1`. It is reused later for CP0 register writes.
- The top level instantiates one `decoder5to32` and 31 enable-gated `WIDTH`-bit registers (generate loop), plus the `WrDone`/`WrIdx` flops.

## Test plan
- **Reset:** hold `Reset`=1 for 2 cycles with `WrEn`=1, `WrAddr`=5, `WrData`=32'hFFFF_FFFF → all `Q*`=0, `WrDone`=0.
- **Single write:** `WrEn`=1, `WrAddr`=5, `WrData`=32'h0000_0005 for 1 cycle → next cycle `Q5`=5, `WrDone`=1, `WrIdx`=5. All other `Q*` remain 0. Reading via `mux32to1` with `Sel`=5 gives `Dout`=5.
- **Full sweep:** write value i to address i for i=0..31, then read with `Sel`=0,1,2,3,4,5,30,31 → `Dout`=0,1,2,3,4,5,30,31. `WrDone` is 0 only for the i=0 write.
- **$0 hardwired:** write 32'hDEAD_BEEF to address 0 → `Q0`=0, `WrDone`=0, `WrIdx` unchanged.
- **Back-to-back and no bypass:** write 32'hA to reg 31, then 32'hB to reg 31 on the next cycle → during the second cycle `Q31`=32'hA, after it `Q31`=32'hB. `WrDone` stays 1 for both cycles.
- **Reset mid-stream:** write 32'h1234 to reg 29, then assert `Reset` together with a write of 32'h5678 to reg 29 → `Q29`=0, `WrDone`=0. The next write after reset deasserts works normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register widths, counts and well-known register indices.
package mips_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/decoder5to32.sv
// 5-bit index to one-hot enable decoder; counterpart of mux32to1, also used for CP0 writes.
module decoder5to32
  import mips_pkg::*;
(
  input  logic                  En,
  input  logic [REG_ADDR_W-1:0] Sel,
  output logic [NUM_REGS-1:0]   Y
);

  always_comb begin
    Y = '0;
    if (En) begin
      Y[Sel] = 1'b1;
    end
  end

endmodule : decoder5to32

// File: rtl/regbank32_write.sv
// Write side of the 32 x WIDTH MIPS register bank: decoded enables, 31 storage registers
// ($0 hardwired to zero) and a registered write-commit strobe with index.
module regbank32_write
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = REG_W
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  WrEn,
  input  logic [REG_ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]      WrData,
  output logic [WIDTH-1:0]      Q0,
  output logic [WIDTH-1:0]      Q1,
  output logic [WIDTH-1:0]      Q2,
  output logic [WIDTH-1:0]      Q3,
  output logic [WIDTH-1:0]      Q4,
  output logic [WIDTH-1:0]      Q5,
  output logic [WIDTH-1:0]      Q6,
  output logic [WIDTH-1:0]      Q7,
  output logic [WIDTH-1:0]      Q8,
  output logic [WIDTH-1:0]      Q9,
  output logic [WIDTH-1:0]      Q10,
  output logic [WIDTH-1:0]      Q11,
  output logic [WIDTH-1:0]      Q12,
  output logic [WIDTH-1:0]      Q13,
  output logic [WIDTH-1:0]      Q14,
  output logic [WIDTH-1:0]      Q15,
  output logic [WIDTH-1:0]      Q16,
  output logic [WIDTH-1:0]      Q17,
  output logic [WIDTH-1:0]      Q18,
  output logic [WIDTH-1:0]      Q19,
  output logic [WIDTH-1:0]      Q20,
  output logic [WIDTH-1:0]      Q21,
  output logic [WIDTH-1:0]      Q22,
  output logic [WIDTH-1:0]      Q23,
  output logic [WIDTH-1:0]      Q24,
  output logic [WIDTH-1:0]      Q25,
  output logic [WIDTH-1:0]      Q26,
  output logic [WIDTH-1:0]      Q27,
  output logic [WIDTH-1:0]      Q28,
  output logic [WIDTH-1:0]      Q29,
  output logic [WIDTH-1:0]      Q30,
  output logic [WIDTH-1:0]      Q31,
  output logic                  WrDone,
  output logic [REG_ADDR_W-1:0] WrIdx
);

  localparam int unsigned NREGS = NUM_REGS;

  logic [NREGS-1:0] w_en;
  logic [WIDTH-1:0] w_q [NREGS];
  logic             w_commit;

  decoder5to32 u_dec (
    .En  (WrEn),
    .Sel (WrAddr),
    .Y   (w_en)
  );

  assign w_q[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic [WIDTH-1:0] r_val;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_val <= '0;
      end else if (w_en[i]) begin
        r_val <= WrData;
      end
    end

    assign w_q[i] = r_val;
  end

  // A write to $0 is decoded but discarded, so it must not raise the commit strobe.
  assign w_commit = WrEn & ~w_en[REG_ZERO];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      WrDone <= 1'b0;
      WrIdx  <= '0;
    end else begin
      WrDone <= w_commit;
      if (w_commit) begin
        WrIdx <= WrAddr;
      end
    end
  end

  assign Q0  = w_q[0];
  assign Q1  = w_q[1];
  assign Q2  = w_q[2];
  assign Q3  = w_q[3];
  assign Q4  = w_q[4];
  assign Q5  = w_q[5];
  assign Q6  = w_q[6];
  assign Q7  = w_q[7];
  assign Q8  = w_q[8];
  assign Q9  = w_q[9];
  assign Q10 = w_q[10];
  assign Q11 = w_q[11];
  assign Q12 = w_q[12];
  assign Q13 = w_q[13];
  assign Q14 = w_q[14];
  assign Q15 = w_q[15];
  assign Q16 = w_q[16];
  assign Q17 = w_q[17];
  assign Q18 = w_q[18];
  assign Q19 = w_q[19];
  assign Q20 = w_q[20];
  assign Q21 = w_q[21];
  assign Q22 = w_q[22];
  assign Q23 = w_q[23];
  assign Q24 = w_q[24];
  assign Q25 = w_q[25];
  assign Q26 = w_q[26];
  assign Q27 = w_q[27];
  assign Q28 = w_q[28];
  assign Q29 = w_q[29];
  assign Q30 = w_q[30];
  assign Q31 = w_q[31];

endmodule : regbank32_write
